// File: rtl/sync_frame_transmitter.sv
// Serial framer: sync word 1011, payload MSB first, optional parity, idle gap.
// Optional even-parity bit enabled by defining SYNC_FRAME_PARITY_EN.
module sync_frame_transmitter #(
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       x_out,
  output logic       busy,
  output logic       frame_done
);

`ifdef SYNC_FRAME_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, PARITY, GAP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, GAP
  } state_t;
`endif

  localparam logic [3:0] SYNC_WORD = 4'b1011;
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_sh;
  logic       r_x;
  logic       r_busy;
  logic       r_done;
`ifdef SYNC_FRAME_PARITY_EN
  logic       r_par;
`endif

  logic [1:0] w_sidx;
  // first sync bit goes out on entry, so the counter points one behind
  assign w_sidx = 2'd2 - r_cnt[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_x    <= 1'b0;
          r_done <= 1'b0;
          if (valid_in) begin
            r_state <= SYNC;
            r_cnt   <= '0;
            r_sh    <= data_in;
            r_x     <= SYNC_WORD[3];
            r_busy  <= 1'b1;
`ifdef SYNC_FRAME_PARITY_EN
            r_par   <= ^data_in;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        SYNC: begin
          if (r_cnt == 4'd3) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_x     <= r_sh[7];
            r_sh    <= {r_sh[6:0], 1'b0};
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_x   <= SYNC_WORD[w_sidx];
          end
        end
        DATA: begin
          if (r_cnt == 4'd7) begin
            r_cnt   <= '0;
`ifdef SYNC_FRAME_PARITY_EN
            r_state <= PARITY;
            r_x     <= r_par;
`else
            r_state <= GAP;
            r_x     <= 1'b0;
            r_done  <= (GAP_LAST == 4'd0);
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_x   <= r_sh[7];
            r_sh  <= {r_sh[6:0], 1'b0};
          end
        end
`ifdef SYNC_FRAME_PARITY_EN
        PARITY: begin
          r_state <= GAP;
          r_cnt   <= '0;
          r_x     <= 1'b0;
          r_done  <= (GAP_LAST == 4'd0);
        end
`endif
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_done <= (r_cnt + 4'd1 == GAP_LAST);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_x     <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out  = (r_state == IDLE);
  assign x_out      = r_x;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_sync_frame_transmitter.sv
// Bench for sync_frame_transmitter: GAP_BITS=2 and GAP_BITS=1 side by side
// against a position-based frame model, plus literal frame checks.
module tb_sync_frame_transmitter;

`ifdef SYNC_FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ro [2];
  logic       xo [2];
  logic       bo [2];
  logic       fo [2];

  always #5 clk = ~clk;

  sync_frame_transmitter #(.GAP_BITS(2)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ro[0]), .x_out(xo[0]), .busy(bo[0]), .frame_done(fo[0])
  );

  sync_frame_transmitter #(.GAP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ro[1]), .x_out(xo[1]), .busy(bo[1]), .frame_done(fo[1])
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int flen(input int k);
    return 12 + PB + ((k == 0) ? 2 : 1);
  endfunction

  // bit p of a frame, straight from the frame layout
  function automatic logic ebit(input logic [7:0] d, input int p);
    logic [3:0] sw;
    sw = 4'b1011;
    if (p < 4) return sw[3-p];
    if (p < 12) return d[11-p];
    if (PB == 1 && p == 12) return ^d;
    return 1'b0;
  endfunction

  function automatic logic [15:0] fvec(input logic [7:0] d, input int k);
    logic [15:0] v;
    v = '0;
    for (int p = 0; p < flen(k); p++) v = {v[14:0], ebit(d, p)};
    return v;
  endfunction

  // model: pos = index of the frame bit on the output, -1 when idle
  int         pos [2] = '{-1, -1};
  logic [7:0] md  [2];

  initial begin
    logic       r, v;
    logic [7:0] d;
    logic       ex, eb, ef, er;
    forever begin
      @(posedge clk);
      r = reset;
      v = valid_in;
      d = data_in;
      for (int k = 0; k < 2; k++) begin
        if (r) pos[k] = -1;
        else if (pos[k] >= 0) begin
          pos[k]++;
          if (pos[k] == flen(k)) pos[k] = -1;
        end else if (v) begin
          pos[k] = 0;
          md[k]  = d;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        ex = (pos[k] >= 0) ? ebit(md[k], pos[k]) : 1'b0;
        eb = (pos[k] >= 0);
        ef = (pos[k] == flen(k) - 1);
        er = (pos[k] < 0);
        chk($sformatf("x_out_g%0d", k), 32'(xo[k]), 32'(ex));
        chk($sformatf("busy_g%0d", k), 32'(bo[k]), 32'(eb));
        chk($sformatf("frame_done_g%0d", k), 32'(fo[k]), 32'(ef));
        chk($sformatf("ready_out_g%0d", k), 32'(ro[k]), 32'(er));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ro[0] === 1'b1 && ro[1] === 1'b1) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  task automatic capture(input int k, input logic [7:0] d,
                         input logic [7:0] d2, output logic [15:0] bits,
                         output int nb, output int fi);
    bits = '0;
    nb = 0;
    fi = -1;
    wait_idle();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bo[k]) begin
        bits = {bits[14:0], xo[k]};
        nb++;
      end
      if (fo[k]) fi = (fi < 0) ? nb - 1 : 99;
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = d2;
    end
  endtask

  logic [15:0] bits;
  logic [15:0] lit;
  int          nb, fi;
  logic        bb [2][40];
  int          g, st, nfd;

  initial begin
    // handshake offered during reset must be dropped
    repeat (3) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 8'hA5;
    end
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(ro[0]), 32'd1);
    chk("idle_after_reset", 32'(bo[0]), 32'd0);

`ifdef SYNC_FRAME_PARITY_EN
    lit = 16'(15'b1011_10100101_0_00);
`else
    lit = 16'(14'b1011_10100101_00);
`endif
    chk("model_A5", fvec(8'hA5, 0), lit);
    capture(0, 8'hA5, 8'hA5, bits, nb, fi);
    chk("frame_A5", bits, lit);
    chk("busy_len_A5", nb, 12 + PB + 2);
    chk("done_idx_A5", fi, 13 + PB);

`ifdef SYNC_FRAME_PARITY_EN
    lit = 16'(15'b1011_00000111_1_00);
`else
    lit = 16'(14'b1011_00000111_00);
`endif
    chk("model_07", fvec(8'h07, 0), lit);
    capture(0, 8'h07, 8'h07, bits, nb, fi);
    chk("frame_07", bits, lit);
    chk("busy_len_07", nb, 14 + PB);

    // back-to-back FF then 00 with valid held high
    wait_idle();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bb[0][i] = bo[0];
      bb[1][i] = bo[1];
      @(negedge clk);
      if (i == 0) data_in = 8'h00;
      if (i == 15) valid_in = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      g = 0;
      st = 0;
      for (int i = 0; i < 40; i++) begin
        if (st == 0 && !bb[k][i]) st = 1;
        if (st == 1) begin
          if (bb[k][i]) st = 2;
          else g++;
        end
      end
      chk($sformatf("b2b_gap_g%0d", k), g, 1);
    end

    // reset during the third payload bit of B2
    wait_idle();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'hB2;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_bit", 32'(xo[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_x", 32'(xo[0]), 32'd0);
    chk("abort_busy", 32'(bo[0]), 32'd0);
    chk("abort_ready", 32'(ro[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    nfd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (fo[0] || fo[1]) nfd++;
    end
    chk("abort_no_done", nfd, 0);

    // data changes right after acceptance
`ifdef SYNC_FRAME_PARITY_EN
    lit = 16'(15'b1011_00111100_0_00);
`else
    lit = 16'(14'b1011_00111100_00);
`endif
    capture(0, 8'h3C, 8'hC3, bits, nb, fi);
    chk("frame_3C", bits, lit);

    // GAP_BITS=1, payload containing the sync pattern
`ifdef SYNC_FRAME_PARITY_EN
    lit = 16'(14'b1011_00001011_1_0);
`else
    lit = 16'(13'b1011_00001011_0);
`endif
    chk("model_0B", fvec(8'h0B, 1), lit);
    capture(1, 8'h0B, 8'h0B, bits, nb, fi);
    chk("frame_0B_g1", bits, lit);
    chk("done_idx_0B_g1", fi, 12 + PB);

    repeat (600) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 59) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 8'($urandom);
    end
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_frame_transmitter.md
SYNC_FRAME_TRANSMITTER -- requirements
Module: sync_frame_transmitter

Interface
REQ-001 SHALL have parameter GAP_BITS, default 2: count of idle 0 bits after each frame, legal range 1..15.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port data_in  input  8  payload byte, sampled on handshake.
REQ-005 SHALL have port valid_in  input  1  payload offered.
REQ-006 SHALL have port ready_out  output  1  block can accept a payload; high exactly when in IDLE.
REQ-007 SHALL have port x_out  output  1  registered serial bit stream, one bit per clk.
REQ-008 SHALL have port busy  output  1  registered; high while any frame bit or gap bit is being driven.
REQ-009 SHALL have port frame_done  output  1  registered one-cycle pulse on the last gap bit of a frame.

Function
REQ-010 SHALL implement states IDLE, SYNC, DATA, PARITY (only when the feature in REQ-025 is compiled in) and GAP.
REQ-011 SHALL accept a payload at a rising edge where valid_in=1, ready_out=1 and reset=0, and latch data_in into an internal shift register.
REQ-012 SHALL ignore valid_in in every state except IDLE; data_in changes after acceptance SHALL NOT affect the frame.
REQ-013 SHALL drive the sync word 1,0,1,1 on x_out in the 4 cycles following the acceptance edge (SYNC state).
REQ-014 SHALL then drive the 8 payload bits MSB first, d7..d0, one per cycle (DATA state).
REQ-015 SHALL then drive GAP_BITS cycles of x_out=0 (GAP state), assert frame_done in the last GAP cycle only, and return to IDLE at the next edge.
REQ-016 SHALL hold x_out=0, busy=0 and frame_done=0 in IDLE.
REQ-017 SHALL keep busy=1 and ready_out=0 from the first SYNC bit through the last GAP bit inclusive: 12+GAP_BITS cycles, or 13+GAP_BITS with parity.
REQ-018 SHALL use a single 4-bit bit counter for SYNC, DATA and GAP; it SHALL reload at every state change and never wrap within a state.
REQ-019 SHALL allow back-to-back frames: a payload offered during the last GAP cycle is accepted at the first IDLE edge, giving exactly one IDLE cycle between frames.
REQ-020 SHALL NOT escape payload bits; a payload containing 1011 is transmitted unchanged.

Reset
REQ-021 SHALL, on any edge with reset=1, enter IDLE and set x_out=0, busy=0, frame_done=0 and bit counter=0, regardless of state.
REQ-022 SHALL have ready_out=1 in the first cycle after reset deasserts; a handshake coincident with reset=1 SHALL be discarded.
REQ-023 SHALL abort a frame interrupted by reset; no remaining bits are sent and frame_done does not pulse.
REQ-024 SHALL hold all outputs at their reset values for the whole time reset stays high.

Configuration
REQ-025 SHALL, when macro SYNC_FRAME_PARITY_EN is defined, insert one PARITY cycle after d0 carrying even parity (XOR of d7..d0) before GAP.
REQ-026 SHALL, without SYNC_FRAME_PARITY_EN, omit the PARITY state and go from d0 directly to GAP.

Verification
REQ-027 SHALL cover: reset, then data_in=8'hA5 accepted with GAP_BITS=2, no parity -> x_out 1011_10100101_00, frame_done high only on the 14th bit, ready_out low for 14 cycles.
REQ-028 SHALL cover: with SYNC_FRAME_PARITY_EN, data_in=8'h07 -> x_out 1011_00000111_1_00, busy high for 15 cycles.
REQ-029 SHALL cover: valid_in held high with 8'hFF then 8'h00 -> two frames separated by exactly one IDLE cycle (x_out=0); second frame payload 00000000.
REQ-030 SHALL cover: reset asserted during the 3rd DATA bit of 8'hB2 -> next cycle x_out=0, busy=0, ready_out=1, no frame_done pulse.
REQ-031 SHALL cover: data_in changed from 8'h3C to 8'hC3 one cycle after acceptance -> payload bits still 00111100.
REQ-032 SHALL cover: GAP_BITS=1, data_in=8'h0B -> x_out 1011_00001011_0, frame_done on the 13th bit, payload 1011 not escaped.
